// File: rtl/bg_write_arbiter.sv
// bg_write_arbiter: four write ports and a RAM clear engine share one background RAM.
// Grants are combinational, and RAM writes are registered with one cycle of latency.
// While the clear engine runs, it zeroes CLEAR_WORDS consecutive words and blocks all ports.
// Optional build macro BG_ARB_ROUND_ROBIN_EN selects round-robin port priority.
// Without it, priority is fixed: port 0 is highest and port 3 is lowest.
module bg_write_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int CLEAR_WORDS = 1200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_window,
  input  logic                clear_start,
  input  logic [3:0]          req,
  input  logic [4*ADDR_W-1:0] addr_in,
  input  logic [4*DATA_W-1:0] data_in,
  output logic [3:0]          gnt,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_data,
  output logic                clear_busy
);

  localparam int               CNT_W     = $clog2(CLEAR_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(CLEAR_WORDS - 1);

  typedef enum logic {S_ARB, S_CLEAR} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] clr_cnt, next_cnt;
  logic             clear_wr;
  logic             grant_ok;
  logic             transfer;
  logic [1:0]       gnt_idx;

  // Ports may only win while arbitration owns the RAM and a clear is not being requested.
  assign grant_ok = !reset && wr_window && !clear_start && (state == S_ARB);
  assign transfer = |gnt;

`ifdef BG_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;
  logic [1:0] search_idx;

  // Round-robin pick: the search runs downward so the port just after rr_ptr is assigned last and wins.
  always_comb begin
    gnt        = '0;
    gnt_idx    = '0;
    search_idx = '0;
    if (grant_ok) begin
      for (int k = 4; k >= 1; k--) begin
        search_idx = rr_ptr + 2'(k);
        if (req[search_idx]) begin
          gnt     = 4'b0001 << search_idx;
          gnt_idx = search_idx;
        end
      end
    end
  end

  // Remember the last granted port; only a completed transfer moves the pointer.
  always_ff @(posedge clk) begin
    if (reset)         rr_ptr <= 2'd3;
    else if (transfer) rr_ptr <= gnt_idx;
  end
`else
  // Fixed-priority pick: scanning from port 3 down lets port 0 take precedence.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (grant_ok) begin
      for (int i = 3; i >= 0; i--) begin
        if (req[i]) begin
          gnt     = 4'b0001 << i;
          gnt_idx = 2'(i);
        end
      end
    end
  end
`endif

  // State and clear counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_ARB;
      clr_cnt <= '0;
    end else begin
      state   <= next_state;
      clr_cnt <= next_cnt;
    end
  end

  // Next-state logic: start or restart clearing, step through words when the window is open, and leave after the last word.
  always_comb begin
    next_state = state;
    next_cnt   = clr_cnt;
    clear_wr   = 1'b0;
    case (state)
      S_ARB: begin
        if (clear_start) begin
          next_state = S_CLEAR;
          next_cnt   = '0;
        end
      end
      S_CLEAR: begin
        if (clear_start) begin
          next_cnt = '0;
        end else if (wr_window) begin
          clear_wr = 1'b1;
          if (clr_cnt == LAST_WORD) begin
            next_state = S_ARB;
            next_cnt   = '0;
          end else begin
            next_cnt = clr_cnt + 1'b1;
          end
        end
      end
      default: begin
        next_state = S_ARB;
        next_cnt   = '0;
      end
    endcase
  end

  // Registered RAM port: capture the granted port's word or a zero clear write.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      clear_busy <= 1'b0;
    end else begin
      ram_we     <= transfer || clear_wr;
      clear_busy <= (next_state == S_CLEAR);
      if (transfer) begin
        ram_addr <= addr_in[gnt_idx*ADDR_W +: ADDR_W];
        ram_data <= data_in[gnt_idx*DATA_W +: DATA_W];
      end else if (clear_wr) begin
        ram_addr <= ADDR_W'(clr_cnt);
        ram_data <= '0;
      end
    end
  end

endmodule

// File: doc/bg_write_arbiter.md
BG_WRITE_ARBITER -- requirements
Module: bg_write_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the width of the background RAM word address.
REQ-002 Parameter DATA_W, default 32, SHALL set the width of the background RAM word.
REQ-003 Parameter CLEAR_WORDS, default 1200, SHALL set the number of words the clear engine zeroes (40x30 tiles).
REQ-004 Clock and reset SHALL be: reset reset, synchronous, active-high; clock clk.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 wr_window  input  1  high = RAM writes permitted this cycle.
REQ-008 clear_start  input  1  single-cycle pulse that starts the clear engine.
REQ-009 req  input  4  per-port write request, port i = bit i.
REQ-010 addr_in  input  4*ADDR_W  per-port address, port i = bits [i*ADDR_W +: ADDR_W].
REQ-011 data_in  input  4*DATA_W  per-port data, port i = bits [i*DATA_W +: DATA_W].
REQ-012 gnt  output  4  one-hot combinational grant; a transfer occurs on port i at a rising edge when req[i] and gnt[i] are both high.
REQ-013 ram_we  output  1  registered background RAM write enable.
REQ-014 ram_addr  output  ADDR_W  registered RAM address.
REQ-015 ram_data  output  DATA_W  registered RAM data.
REQ-016 clear_busy  output  1  registered; high while the clear engine owns the RAM.

Function
REQ-017 The FSM SHALL have two states, S_ARB and S_CLEAR.
REQ-018 In S_ARB with wr_window=1, gnt SHALL select exactly one requesting port, and gnt SHALL be 0 when req=0.
REQ-019 gnt SHALL be all-zero whenever wr_window=0, the state is S_CLEAR, clear_start=1, or reset=1.
REQ-020 gnt[i] SHALL depend only on req, wr_window, clear_start, state, reset and the priority pointer, with no path from addr_in or data_in.
REQ-021 A transfer on port i SHALL make ram_we=1, ram_addr=addr_in[i] and ram_data=data_in[i] in the next cycle (1-cycle latency).
REQ-022 ram_we SHALL be 0 in every cycle that follows a cycle with no transfer and no clear write.
REQ-023 A requester SHALL hold req, addr and data stable until granted, and the arbiter SHALL NOT drop a pending request.
REQ-024 clear_start=1 in S_ARB SHALL move the FSM to S_CLEAR with the clear counter at 0; any same-cycle request SHALL lose.
REQ-025 In S_CLEAR, each cycle with wr_window=1 SHALL issue a write of address = counter and data = 0, then increment the counter; cycles with wr_window=0 SHALL stall the counter.
REQ-026 The FSM SHALL return to S_ARB in the cycle after the write of address CLEAR_WORDS-1 is issued; clear_busy SHALL fall at the same time.
REQ-027 clear_start during S_CLEAR SHALL restart the counter at 0.
REQ-028 The clear counter SHALL be ceil(log2(CLEAR_WORDS+1)) bits wide, and ram_addr SHALL be its zero-extended value.

Reset
REQ-029 On reset, the FSM SHALL enter S_ARB, the clear counter SHALL be 0, and ram_we, ram_addr, ram_data and clear_busy SHALL be 0.
REQ-030 On reset, the round-robin pointer SHALL be 3, so port 0 is searched first.
REQ-031 Reset asserted mid-clear SHALL abort the clear, with no further writes.

Configuration
REQ-032 With macro BG_ARB_ROUND_ROBIN_EN defined, the search order SHALL start at the port after the last granted port, and the pointer SHALL update only on a transfer.
REQ-033 Without BG_ARB_ROUND_ROBIN_EN, priority SHALL be fixed with port 0 highest and port 3 lowest, and no pointer register SHALL exist.

Verification
REQ-034 Scenario: reset, then wr_window=1 and req=0001 with addr 0x0028 and data 0x0000_A405 -> gnt=0001 the same cycle; the next cycle has ram_we=1, ram_addr=0x0028, ram_data=0x0000_A405.
REQ-035 Scenario: req=1111 held for 8 cycles with the macro defined -> gnt sequence 0001, 0010, 0100, 1000, 0001...; without the macro -> gnt=0001 every cycle.
REQ-036 Scenario: clear_start pulse with wr_window=1 -> exactly 1200 consecutive writes at addresses 0..1199, data 0; clear_busy high for 1200 cycles; gnt=0 throughout.
REQ-037 Scenario: wr_window toggled 0 for 5 cycles mid-clear -> the counter holds, the total write count is still 1200, and the last address is 1199.
REQ-038 Scenario: clear_start at counter 600 -> the next write address is 0, and 1200 further writes follow.
REQ-039 Scenario: reset asserted at clear counter 300 -> the next cycle has ram_we=0 and clear_busy=0, and no further writes occur.
